// File: rtl/dlx_if_pkg.sv
// Shared types and constants for the DLX instruction-fetch stage.
package dlx_if_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_FULL
  } state_e;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

  localparam logic [0:INSTR_W-1] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [0:INSTR_W-1] instr;
    logic [31:0]        npc;
  } skid_entry_t;

  // Wait counter needs at least one bit even for a zero-wait SRAM.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/dlx_ifetch_if.sv
// Fetch-stage bus: instruction SRAM, IF/ID slot and decode/redirect controls.
interface dlx_ifetch_if;
  import dlx_if_pkg::*;

  logic                 imem_cs;
  logic                 imem_oe;
  logic                 imem_we;
  logic [31:0]          imem_addr;
  logic [0:INSTR_W-1]   imem_dout;
  logic                 id_stall;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic [0:INSTR_W-1]   if_id_instr;
  logic [31:0]          if_id_npc;
  logic                 if_id_valid;

  modport master (
    output imem_cs, imem_oe, imem_we, imem_addr,
    output if_id_instr, if_id_npc, if_id_valid,
    input  imem_dout, id_stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_cs, imem_oe, imem_we, imem_addr,
    input  if_id_instr, if_id_npc, if_id_valid,
    output imem_dout, id_stall, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/dlx_if_skid.sv
// One-entry skid buffer catching a fetch that completes while decode is stalled.
module dlx_if_skid
  import dlx_if_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_load,
  input  logic               i_unload,
  input  logic               i_flush,
  input  logic [0:INSTR_W-1] i_instr,
  input  logic [31:0]        i_npc,
  output logic               o_full,
  output logic [0:INSTR_W-1] o_instr,
  output logic [31:0]        o_npc
);

  logic        r_full;
  skid_entry_t r_entry;

  // Flush wins so a redirect can never leave a stale entry behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full  <= 1'b0;
      r_entry <= '0;
    end else if (i_flush) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full        <= 1'b1;
      r_entry.instr <= i_instr;
      r_entry.npc   <= i_npc;
    end else if (i_unload) begin
      r_full <= 1'b0;
    end
  end

  assign o_full  = r_full;
  assign o_instr = r_entry.instr;
  assign o_npc   = r_entry.npc;

endmodule

// File: rtl/dlx_ifetch.sv
// DLX instruction fetch: PC, SRAM wait-state sequencing, IF/ID slot, skid and redirect.
module dlx_ifetch
  import dlx_if_pkg::*;
#(
  parameter logic [31:0]        RESET_PC  = 32'h0000_0000,
  parameter int                 MEM_WAIT  = 0,
  parameter logic [0:INSTR_W-1] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  dlx_ifetch_if.master  bus
);

  localparam int             CNT_W    = cnt_width(MEM_WAIT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_WAIT);

  state_e             r_state, w_state_next;
  logic [31:0]        r_pc, w_pc_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [0:INSTR_W-1] r_instr, w_instr_next;
  logic [31:0]        r_npc, w_npc_next;
  logic               r_valid, w_valid_next;

  logic               w_skid_load, w_skid_unload, w_skid_flush;
  logic               w_skid_full;
  logic [0:INSTR_W-1] w_skid_instr;
  logic [31:0]        w_skid_npc;
  logic [31:0]        w_pc_inc;
  logic               w_consume;

  assign w_pc_inc  = r_pc + PC_INC;
  assign w_consume = r_valid && !bus.id_stall;

  dlx_if_skid u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_flush  (w_skid_flush),
    .i_instr  (bus.imem_dout),
    .i_npc    (w_pc_inc),
    .o_full   (w_skid_full),
    .o_instr  (w_skid_instr),
    .o_npc    (w_skid_npc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_cnt   <= CNT_INIT;
      r_instr <= NOP_INSTR;
      r_npc   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_cnt   <= w_cnt_next;
      r_instr <= w_instr_next;
      r_npc   <= w_npc_next;
      r_valid <= w_valid_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_cnt_next    = r_cnt;
    w_instr_next  = r_instr;
    w_npc_next    = r_npc;
    w_valid_next  = r_valid;
    w_skid_load   = 1'b0;
    w_skid_unload = 1'b0;
    w_skid_flush  = 1'b0;

    // Empty the slot on consumption; a load below overrides this.
    if (w_consume) begin
      w_valid_next = 1'b0;
      w_instr_next = NOP_INSTR;
    end

    unique case (r_state)
      S_IDLE: begin
        w_state_next = S_ACCESS;
        w_cnt_next   = CNT_INIT;
      end
      S_ACCESS: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end else if (!r_valid || !bus.id_stall) begin
          w_instr_next = bus.imem_dout;
          w_npc_next   = w_pc_inc;
          w_valid_next = 1'b1;
          w_pc_next    = w_pc_inc;
          w_cnt_next   = CNT_INIT;
        end else begin
          w_skid_load  = 1'b1;
          w_pc_next    = w_pc_inc;
          w_state_next = S_FULL;
        end
      end
      S_FULL: begin
        if (!bus.id_stall && w_skid_full) begin
          w_instr_next  = w_skid_instr;
          w_npc_next    = w_skid_npc;
          w_valid_next  = 1'b1;
          w_skid_unload = 1'b1;
          w_cnt_next    = CNT_INIT;
          w_state_next  = S_ACCESS;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // Redirect squashes everything in flight, whatever the state or stall.
    if (bus.redirect_valid) begin
      w_pc_next     = bus.redirect_pc & ADDR_MASK;
      w_valid_next  = 1'b0;
      w_instr_next  = NOP_INSTR;
      w_skid_load   = 1'b0;
      w_skid_unload = 1'b0;
      w_skid_flush  = 1'b1;
      w_cnt_next    = CNT_INIT;
      w_state_next  = S_ACCESS;
    end
  end

  assign bus.imem_cs     = (r_state == S_ACCESS);
  assign bus.imem_oe     = (r_state == S_ACCESS);
  assign bus.imem_we     = 1'b0;
  assign bus.imem_addr   = r_pc & ADDR_MASK;
  assign bus.if_id_instr = r_instr;
  assign bus.if_id_npc   = r_npc;
  assign bus.if_id_valid = r_valid;

endmodule

// File: doc/dlx_ifetch.md
Name: dlx_ifetch

Overview:
- Instruction-fetch stage of the DLX pipeline.
- Owns the PC, drives the instruction SRAM (`cs`/`oe`/`we`/`addr`) and samples its big-endian `dout[0:31]`.
- Delivers instruction and PC+4 to the IF/ID register consumed by decode.
- Handles decode back-pressure with a one-entry skid buffer, branch/jump redirects with squash, and a programmable SRAM wait-state count.

Parameters:
- `RESET_PC`, `32'h0000_0000`: PC loaded on reset.
- `MEM_WAIT`, `0`: extra cycles `imem_addr` is held stable before `imem_dout` is sampled (0 = combinational SRAM).
- `NOP_INSTR`, `32'h0000_0000`: encoding driven on `if_id_instr` when the slot is empty or squashed.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `imem_cs`  out  1  SRAM chip select.
- `imem_oe`  out  1  SRAM output enable.
- `imem_we`  out  1  SRAM write enable, tied 0.
- `imem_addr`  out  32  fetch byte address (= PC).
- `imem_dout`  in  [0:31]  instruction word from SRAM, bit 0 = opcode MSB.
- `id_stall`  in  1  decode cannot accept the IF/ID slot this cycle.
- `redirect_valid`  in  1  branch/jump taken; refetch from `redirect_pc`.
- `redirect_pc`  in  32  target byte address.
- `if_id_instr`  out  [0:31]  fetched instruction.
- `if_id_npc`  out  32  address of the instruction + 4.
- `if_id_valid`  out  1  slot holds a live instruction.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - `pc=RESET_PC`, state=`S_IDLE`, wait counter=`MEM_WAIT`, skid empty.
  - `if_id_valid=0`, `if_id_instr=NOP_INSTR`, `if_id_npc=0`.
  - `imem_cs=0`, `imem_oe=0`; `imem_we=0` always.
- `imem_addr = {pc[31:2],2'b00}` combinationally in every state.
- State machine:
  - `S_IDLE`: `cs`/`oe` low. At the first edge after reset release go to `S_ACCESS` with `cnt=MEM_WAIT`.
  - `S_ACCESS`: `cs`/`oe` high.
    - `cnt>0`: decrement.
    - `cnt==0`: the fetch completes at this edge.
      - Slot free (`!if_id_valid || !id_stall`): load `if_id_instr=imem_dout`, `if_id_npc=pc+4`, `valid=1`; `pc+=4`; `cnt=MEM_WAIT`; stay.
      - Slot blocked: load skid with `{imem_dout, pc+4}`; `pc+=4`; go to `S_FULL`.
  - `S_FULL`: `cs`/`oe` low; no new fetch.
    - When the slot frees (`!id_stall`), move skid to IF/ID, `cnt=MEM_WAIT`, go to `S_ACCESS`.
- Throughput and latency:
  - With `MEM_WAIT=0`, one instruction per cycle sustained.
  - The address presented in cycle t appears on `if_id_*` in cycle t+1.
  - Each fetch occupies `MEM_WAIT+1` cycles.
- Consumption: the slot is consumed at an edge where `if_id_valid && !id_stall`. If nothing new loads at that edge, set `valid=0` and `instr=NOP_INSTR`.
- Stall hold: while `id_stall=1` and `valid=1`, `if_id_*` is held bit-stable.
- Redirect (highest priority; overrides stall, fetch completion and `S_FULL`):
  - At the edge: `pc={redirect_pc[31:2],2'b00}`.
  - IF/ID squashed (`valid=0`, `instr=NOP_INSTR`); skid discarded; in-flight fetch abandoned.
  - `cnt=MEM_WAIT`, state=`S_ACCESS`.
  - The target instruction is valid `MEM_WAIT+1` cycles later.
- Redirect in `S_IDLE`: take the redirect target instead of `RESET_PC`.
- PC wrap: `32'hFFFF_FFFC+4` wraps to 0; `npc` wraps identically.
- Reset asserted mid-fetch or mid-stall: all state returns to reset values immediately (asynchronous). The skid contents are lost.

Decomposition:
- Package `dlx_if_pkg`:
  - state enum `{S_IDLE, S_ACCESS, S_FULL}`;
  - `INSTR_W=32`, `PC_INC=4`;
  - default `NOP_INSTR`.
- One sub-module, `dlx_if_skid`: one-entry buffer with `load`/`unload`/`flush`, data `{instr[0:31], npc[31:0]}` and a `full` flag.
- The PC, wait counter and FSM stay in `dlx_ifetch`.

Test Plan:
- Reset release, `MEM_WAIT=0`, SRAM model returns `32'h2001AAAA` at 0x0 and `32'h80030080` at 0x4:
  - edge 2 after release: `if_id_instr=2001AAAA`, `npc=4`, `valid=1`;
  - edge 3: `80030080`, `npc=8`.
- `id_stall` high for 3 cycles while valid, at PC=0x8:
  - IF/ID held stable;
  - the 0x8 word goes to skid and `imem_cs=0` during `S_FULL`;
  - on release the 0x8 word is delivered and fetching resumes at 0xC with no loss or duplication.
- `redirect_valid` with `redirect_pc=0x80`, concurrent with `id_stall=1` and skid full:
  - next cycle `valid=0` and `instr=NOP_INSTR`;
  - the following cycle `instr=F0F0F0F0`, `npc=0x84`.
- `MEM_WAIT=2`, sequential fetch from 0: `imem_addr` is held 3 cycles per word; one valid instruction every 3 cycles.
- Misaligned redirect `redirect_pc=0x13`: `imem_addr=0x10`, `npc=0x14`.
- `reset_n` pulsed low mid-stall with skid full: `valid=0`, `cs=0`, `pc=RESET_PC` immediately (before the next clock edge); the fetch restarts at `RESET_PC` after release.
